wvb_readout_arbiter: RTL

Round-robin readout controller that shares one downstream readout port among P_N_CHAN waveform_buffer instances. It selects a channel with a pending header, pops the header, then streams that waveform's data words with valid/ready backpressure and closes the readout with wvb_rddone. It sits between the per-channel waveform_acquisition blocks and the transfer/DMA logic.

---
 rtl/wvb_arb_pkg.sv | 17 +
 rtl/wvb_rd_skid.sv | 52 +++++
 rtl/wvb_readout_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/wvb_arb_pkg.sv
// Shared definitions for the waveform-buffer readout arbiter:
// FSM state encoding and the location of the length field inside a header.
package wvb_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_POP = 3'd1,
    ST_HDR_OUT = 3'd2,
    ST_DATA    = 3'd3,
    ST_DONE    = 3'd4
  } arb_state_t;

  // Header bits [HDR_LEN_LSB +: HDR_LEN_W] hold (word count - 1).
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_W   = 15;

endpackage

// File: rtl/wvb_rd_skid.sv
// Two-entry skid FIFO between the buffer read port and the downstream
// valid/ready data port. A last flag travels with every word. The producer
// guarantees it never pushes into a full FIFO. Output data reads as zero
// whenever the FIFO is empty.
module wvb_rd_skid #(
  parameter int DATA_W = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              pop,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_data [2];
  logic [1:0]        mem_last;
  logic              rptr;
  logic              wptr;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & pop_ready;
  assign out_data  = out_valid ? mem_data[rptr] : '0;
  assign out_last  = out_valid & mem_last[rptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage for word and last flag; contents are only observed while valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wptr] <= push_data;
      mem_last[wptr] <= push_last;
    end
  end

endmodule

// File: rtl/wvb_readout_arbiter.sv
// Round-robin readout arbiter sharing one downstream port among P_N_CHAN
// waveform buffers: grant, pop header, present header, stream data words
// through a 2-entry skid FIFO, then pulse rddone.
// Optional build macro WVB_ARB_STATS_EN adds stats_clr input and the
// per-channel saturating waveform counters on wvf_count.
module wvb_readout_arbiter
  import wvb_arb_pkg::*;
#(
  parameter int P_N_CHAN     = 4,
  parameter int P_DATA_WIDTH = 28,
  parameter int P_HDR_WIDTH  = 87,
  parameter int P_ADR_WIDTH  = HDR_LEN_W,
  parameter int P_CHAN_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             arb_en,
  input  logic [P_N_CHAN-1:0]              chan_mask,
  input  logic [P_N_CHAN-1:0]              wvb_hdr_empty,
  input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]  wvb_hdr_data_in,
  input  logic [P_N_CHAN*P_DATA_WIDTH-1:0] wvb_data_in,
  output logic [P_N_CHAN-1:0]              wvb_hdr_rdreq,
  output logic [P_N_CHAN-1:0]              wvb_rdreq,
  output logic [P_N_CHAN-1:0]              wvb_rddone,
  output logic [P_HDR_WIDTH-1:0]           out_hdr,
  output logic [P_CHAN_WIDTH-1:0]          out_hdr_chan,
  output logic                             out_hdr_valid,
  input  logic                             out_hdr_ready,
  output logic [P_DATA_WIDTH-1:0]          out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             busy
`ifdef WVB_ARB_STATS_EN
  ,
  input  logic                             stats_clr,
  output logic [P_N_CHAN*16-1:0]           wvf_count
`endif
);

  arb_state_t               state;
  arb_state_t               state_nxt;
  logic [P_CHAN_WIDTH-1:0]  cur;
  logic [P_CHAN_WIDTH-1:0]  rr;
  logic [P_CHAN_WIDTH-1:0]  grant;
  logic [P_N_CHAN-1:0]      elig;
  logic [P_HDR_WIDTH-1:0]   hdr_arr  [P_N_CHAN];
  logic [P_DATA_WIDTH-1:0]  data_arr [P_N_CHAN];
  logic [P_ADR_WIDTH-1:0]   req_cnt;
  logic                     req_done;
  logic                     vld_p1;
  logic                     last_p1;
  logic                     rd_go;
  logic [2:0]               occ;
  logic                     skid_pop;
  logic                     skid_last;
  logic [1:0]               skid_cnt;

  // First eligible channel at or after ptr, wrapping around.
  function automatic logic [P_CHAN_WIDTH-1:0] rr_pick(
    input logic [P_N_CHAN-1:0]     el,
    input logic [P_CHAN_WIDTH-1:0] ptr
  );
    logic [P_CHAN_WIDTH-1:0] sel;
    logic [P_CHAN_WIDTH-1:0] idx;
    logic                    found;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < P_N_CHAN; k++) begin
      idx = P_CHAN_WIDTH'((int'(ptr) + k) % P_N_CHAN);
      if (!found && el[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [P_N_CHAN-1:0] onehot(input logic [P_CHAN_WIDTH-1:0] sel);
    logic [P_N_CHAN-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  // Split the flat per-channel buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < P_N_CHAN; i++) begin
      hdr_arr[i]  = wvb_hdr_data_in[i*P_HDR_WIDTH +: P_HDR_WIDTH];
      data_arr[i] = wvb_data_in[i*P_DATA_WIDTH +: P_DATA_WIDTH];
    end
  end

  assign elig  = chan_mask & ~wvb_hdr_empty;
  assign grant = rr_pick(elig, rr);
  assign busy  = (state != ST_IDLE);

  // Next-state logic and read-request gating. A request is allowed while
  // the word in flight plus the skid contents remaining after this cycle's
  // pop leave room for one more, which sustains one word per cycle.
  always_comb begin
    state_nxt = state;
    occ       = {2'b00, vld_p1} + {1'b0, skid_cnt} - {2'b00, skid_pop};
    rd_go     = 1'b0;
    wvb_rdreq = '0;
    unique case (state)
      ST_IDLE:    if (arb_en && (|elig)) state_nxt = ST_HDR_POP;
      ST_HDR_POP: state_nxt = ST_HDR_OUT;
      ST_HDR_OUT: if (out_hdr_ready) state_nxt = ST_DATA;
      ST_DATA: begin
        rd_go = !req_done && (occ < 3'd2);
        if (skid_pop && skid_last) state_nxt = ST_DONE;
      end
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (rd_go) wvb_rdreq = onehot(cur);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Grant, header latch, word counter and registered one-hot pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur           <= '0;
      rr            <= '0;
      wvb_hdr_rdreq <= '0;
      wvb_rddone    <= '0;
      out_hdr       <= '0;
      out_hdr_chan  <= '0;
      out_hdr_valid <= 1'b0;
      req_cnt       <= '0;
      req_done      <= 1'b0;
      vld_p1        <= 1'b0;
      last_p1       <= 1'b0;
    end else begin
      wvb_hdr_rdreq <= '0;
      wvb_rddone    <= '0;
      unique case (state)
        ST_IDLE: begin
          if (state_nxt == ST_HDR_POP) begin
            cur           <= grant;
            wvb_hdr_rdreq <= onehot(grant);
          end
        end
        ST_HDR_POP: begin
          out_hdr       <= hdr_arr[cur];
          out_hdr_chan  <= cur;
          out_hdr_valid <= 1'b1;
          req_cnt       <= hdr_arr[cur][HDR_LEN_LSB +: P_ADR_WIDTH];
          req_done      <= 1'b0;
        end
        ST_HDR_OUT: begin
          if (out_hdr_ready) out_hdr_valid <= 1'b0;
        end
        ST_DATA: begin
          if (state_nxt == ST_DONE) wvb_rddone <= onehot(cur);
        end
        ST_DONE: begin
          rr <= (cur == P_CHAN_WIDTH'(P_N_CHAN - 1)) ? '0 : cur + P_CHAN_WIDTH'(1);
        end
        default: ;
      endcase
      if (rd_go) begin
        if (req_cnt == '0) req_done <= 1'b1;
        else               req_cnt  <= req_cnt - P_ADR_WIDTH'(1);
      end
      // ---- stage p1: buffer read data arrives one cycle after the request
      vld_p1  <= rd_go;
      last_p1 <= rd_go && (req_cnt == '0);
    end
  end

  wvb_rd_skid #(
    .DATA_W (P_DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_p1),
    .push_data (data_arr[cur]),
    .push_last (last_p1),
    .pop_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (skid_last),
    .pop       (skid_pop),
    .count     (skid_cnt)
  );

  assign out_last = skid_last;

`ifdef WVB_ARB_STATS_EN
  // Per-channel completed-waveform counters; clear has priority, saturate at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wvf_count <= '0;
    end else begin
      for (int i = 0; i < P_N_CHAN; i++) begin
        if (stats_clr)
          wvf_count[i*16 +: 16] <= '0;
        else if (wvb_rddone[i] && (wvf_count[i*16 +: 16] != 16'hFFFF))
          wvf_count[i*16 +: 16] <= wvf_count[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
